inst_prefetch_buffer: RTL and testbench

Instruction prefetch buffer between the instruction memory port and the IF/ID pipeline register of the 5-stage MIPS core. It issues sequential word fetches to a pipelined, in-order instruction memory, queues returned instructions with their PC and PC+4, and presents them one per cycle to IF/ID. Branch and jump redirects from ID flush the queue and discard responses still in flight. IF/ID stalls hold the head entry.

---
 rtl/inst_prefetch_buffer.sv | 150 +++++++++++++++
 tb/tb_inst_prefetch_buffer.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/inst_prefetch_buffer.sv
// Instruction prefetch buffer: issues sequential fetches to a pipelined in-order
// instruction memory and queues {instr, pc} for the IF/ID register.
module inst_prefetch_buffer #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic        deq,
  output logic        inst_valid,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  output logic [31:0] inst_pc_plus4
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = AW + 1;
  localparam logic [CW:0] DEPTH_C = (CW + 1)'(DEPTH);

  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [31:0]   resp_pc_q, resp_pc_d;
  logic [31:0]   instr_q [DEPTH];
  logic [31:0]   pc_q    [DEPTH];
  logic [AW-1:0] head_q, head_d;
  logic [AW-1:0] tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;
  logic [CW-1:0] outst_q, outst_d;
  logic [CW-1:0] drop_q, drop_d;

  logic [CW:0]   credit_s;
  logic [31:0]   target_s;
  logic          grant_s;
  logic          rsp_s;
  logic          push_s;
  logic          pop_s;
  logic          redir_unused_s;

  // Credit check: every queued or in-flight fetch owns a queue slot.
  always_comb begin
    credit_s  = {1'b0, count_q} + {1'b0, outst_q};
    imem_req  = !rst && !redirect && (credit_s < DEPTH_C);
    imem_addr = fetch_pc_q;
  end

  assign target_s       = {redirect_pc[31:2], 2'b00};
  assign redir_unused_s = ^redirect_pc[1:0];
  assign grant_s        = imem_req && imem_gnt;
  assign rsp_s          = imem_rvalid && !rst;
  assign push_s         = rsp_s && !redirect && (drop_q == {CW{1'b0}});
  assign inst_valid     = (count_q != {CW{1'b0}});
  assign pop_s          = deq && inst_valid && !redirect;

  // Next-state logic for pointers, counters and PCs.
  always_comb begin
    fetch_pc_d = fetch_pc_q;
    resp_pc_d  = resp_pc_q;
    head_d     = head_q;
    tail_d     = tail_q;
    count_d    = count_q;
    drop_d     = drop_q;
    outst_d    = outst_q + {{(CW-1){1'b0}}, grant_s} - {{(CW-1){1'b0}}, rsp_s};

    if (redirect) begin
      // Everything still in flight becomes stale; the response landing now is dropped too.
      fetch_pc_d = target_s;
      resp_pc_d  = target_s;
      head_d     = {AW{1'b0}};
      tail_d     = {AW{1'b0}};
      count_d    = {CW{1'b0}};
      drop_d     = outst_q - {{(CW-1){1'b0}}, rsp_s};
    end else begin
      if (grant_s) begin
        fetch_pc_d = fetch_pc_q + 32'd4;
      end else begin
        fetch_pc_d = fetch_pc_q;
      end
      if (push_s) begin
        tail_d    = tail_q + {{(AW-1){1'b0}}, 1'b1};
        resp_pc_d = resp_pc_q + 32'd4;
      end else begin
        tail_d    = tail_q;
        resp_pc_d = resp_pc_q;
      end
      if (pop_s) begin
        head_d = head_q + {{(AW-1){1'b0}}, 1'b1};
      end else begin
        head_d = head_q;
      end
      if (rsp_s && (drop_q != {CW{1'b0}})) begin
        drop_d = drop_q - {{(CW-1){1'b0}}, 1'b1};
      end else begin
        drop_d = drop_q;
      end
      count_d = count_q + {{(CW-1){1'b0}}, push_s} - {{(CW-1){1'b0}}, pop_s};
    end
  end

  // Control state register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc_q <= RESET_PC;
      resp_pc_q  <= RESET_PC;
      head_q     <= {AW{1'b0}};
      tail_q     <= {AW{1'b0}};
      count_q    <= {CW{1'b0}};
      outst_q    <= {CW{1'b0}};
      drop_q     <= {CW{1'b0}};
    end else begin
      fetch_pc_q <= fetch_pc_d;
      resp_pc_q  <= resp_pc_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      outst_q    <= outst_d;
      drop_q     <= drop_d;
    end
  end

  // Queue storage; contents are only observed through a valid head.
  always_ff @(posedge clk) begin
    if (push_s) begin
      instr_q[tail_q] <= imem_rdata;
      pc_q[tail_q]    <= resp_pc_q;
    end else begin
      instr_q[tail_q] <= instr_q[tail_q];
      pc_q[tail_q]    <= pc_q[tail_q];
    end
  end

  // Head mux: registers only, zeroed when empty.
  always_comb begin
    if (inst_valid) begin
      inst          = instr_q[head_q];
      inst_pc       = pc_q[head_q];
      inst_pc_plus4 = pc_q[head_q] + 32'd4;
    end else begin
      inst          = 32'h0000_0000;
      inst_pc       = 32'h0000_0000;
      inst_pc_plus4 = 32'h0000_0000;
    end
  end

endmodule

// File: tb/tb_inst_prefetch_buffer.sv
// Randomized and directed bench for inst_prefetch_buffer against a queue-level
// model of fetches in flight and instructions waiting for IF/ID.
module tb_inst_prefetch_buffer;
  localparam int          DEPTH = 4;
  localparam logic [31:0] RPC   = 32'h0000_3000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt = 1'b0;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = 32'h0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        deq = 1'b0;
  logic        inst_valid;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic [31:0] inst_pc_plus4;

  always #5 clk = ~clk;

  inst_prefetch_buffer #(.DEPTH(DEPTH), .RESET_PC(RPC)) dut (
    .clk(clk), .rst(rst), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_gnt(imem_gnt), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .redirect(redirect), .redirect_pc(redirect_pc), .deq(deq),
    .inst_valid(inst_valid), .inst(inst), .inst_pc(inst_pc),
    .inst_pc_plus4(inst_pc_plus4)
  );

  // Memory side: one record per granted fetch, in issue order.
  typedef struct { logic [31:0] addr; logic [31:0] pc_exp; int due; bit stale; } fl_t;
  typedef struct { logic [31:0] instr; logic [31:0] pc; } ent_t;
  fl_t  mem_q[$];
  ent_t mq[$];

  logic [31:0] fpc = RPC;
  logic [31:0] xmask = 32'h0;
  int cyc = 0;
  int total = 0;
  int bad = 0;

  bit          obs_valid, obs_req, obs_grant, obs_pop;
  logic [31:0] obs_addr, obs_inst, obs_pc, obs_pc4;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%h expected=%h", name, cyc, act, exp);
    end
  endtask

  // One clock: drive at negedge, compare 1ns later, then advance the model past the posedge.
  task automatic step(input bit r, input bit rd, input logic [31:0] rpc,
                      input bit dq, input bit g, input int lat);
    bit rv, pop_ok, exp_req, exp_valid;
    fl_t f;
    ent_t e;
    logic [31:0] e_inst, e_pc;
    @(negedge clk);
    rst = r; redirect = rd; redirect_pc = rpc; deq = dq; imem_gnt = g;
    rv = (mem_q.size() > 0) && (mem_q[0].due <= cyc);
    if (r) begin
      imem_rvalid = 1'b1;
      imem_rdata  = 32'hBAD0_0000 ^ 32'(cyc);
    end else begin
      imem_rvalid = rv;
      imem_rdata  = rv ? (mem_q[0].addr ^ xmask) : 32'h0;
    end
    #1;
    exp_valid = (mq.size() > 0);
    e_inst = exp_valid ? mq[0].instr : 32'h0;
    e_pc   = exp_valid ? mq[0].pc : 32'h0;
    exp_req = !r && !rd && ((mq.size() + mem_q.size()) < DEPTH);
    chk("inst_valid", inst_valid, exp_valid);
    chk("inst", inst, e_inst);
    chk("inst_pc", inst_pc, e_pc);
    chk("inst_pc_plus4", inst_pc_plus4, exp_valid ? e_pc + 32'd4 : 32'h0);
    chk("imem_req", imem_req, exp_req);
    if (exp_req) chk("imem_addr", imem_addr, fpc);
    obs_valid = inst_valid; obs_req = imem_req; obs_addr = imem_addr;
    obs_inst = inst; obs_pc = inst_pc; obs_pc4 = inst_pc_plus4;
    obs_grant = imem_req && imem_gnt;
    obs_pop = dq && inst_valid && !rd && !r;
    if (r) begin
      mq.delete();
      mem_q.delete();
      fpc = RPC;
    end else begin
      pop_ok = dq && (mq.size() > 0) && !rd;
      if (pop_ok) void'(mq.pop_front());
      if (rv) begin
        f = mem_q.pop_front();
        if (!f.stale && !rd) begin
          e.instr = f.pc_exp ^ xmask;
          e.pc    = f.pc_exp;
          mq.push_back(e);
        end
      end
      if (rd) begin
        mq.delete();
        foreach (mem_q[i]) mem_q[i].stale = 1'b1;
        fpc = {rpc[31:2], 2'b00};
      end
      if (imem_req && imem_gnt) begin
        f.addr = imem_addr; f.pc_exp = fpc; f.due = cyc + lat; f.stale = rd;
        mem_q.push_back(f);
        fpc = fpc + 32'd4;
      end
    end
    cyc++;
  endtask

  task automatic do_reset();
    step(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1);
    step(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1);
  endtask

  initial begin
    int first_v, ngr, n;
    bit found;
    logic [31:0] fi, fp, f4;

    // Reset and sequential fetch, rdata = address.
    xmask = 32'h0;
    do_reset();
    chk("reset_valid", obs_valid, 1'b0);
    chk("reset_req", obs_req, 1'b0);
    chk("reset_inst", obs_inst, 32'h0);
    chk("reset_pc", obs_pc, 32'h0);
    chk("reset_pc4", obs_pc4, 32'h0);
    first_v = -1; fi = 32'h0; fp = 32'h0; f4 = 32'h0;
    for (int k = 0; k < 8; k++) begin
      step(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 1);
      if (k < 4) chk("addr_seq", obs_addr, 32'h3000 + 32'(4 * k));
      if (k == 0) chk("first_grant", obs_grant, 1'b1);
      if (obs_valid && first_v < 0) begin
        first_v = k; fi = obs_inst; fp = obs_pc; f4 = obs_pc4;
      end
    end
    chk("first_valid_cycle", 32'(first_v), 32'd2);
    chk("first_inst", fi, 32'h3000);
    chk("first_pc", fp, 32'h3000);
    chk("first_pc4", f4, 32'h3004);

    // Stall until full, then drain.
    do_reset();
    ngr = 0;
    for (int k = 0; k < 10; k++) begin
      step(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 1);
      if (obs_grant) ngr++;
    end
    chk("full_grants", 32'(ngr), 32'd4);
    chk("full_req_low", obs_req, 1'b0);
    chk("full_head", obs_pc, 32'h3000);
    n = 0;
    for (int k = 0; k < 20 && n < 4; k++) begin
      step(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 1);
      if (obs_pop) begin
        chk("drain_pc", obs_pc, 32'h3000 + 32'(4 * n));
        n++;
      end
    end
    chk("drain_count", 32'(n), 32'd4);

    // Redirect with two fetches in flight, latency 3.
    do_reset();
    step(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 3);
    step(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 3);
    chk("inflight_before_redirect", 32'(mem_q.size()), 32'd2);
    step(1'b0, 1'b1, 32'h0000_4002, 1'b0, 1'b1, 3);
    n = 0;
    for (int k = 0; k < 30 && n < 2; k++) begin
      step(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 3);
      if (obs_pop) begin
        chk("redirect_pc_seq", obs_pc, 32'h4000 + 32'(4 * n));
        n++;
      end
    end
    chk("redirect_delivered", 32'(n), 32'd2);

    // Redirect coinciding with a response and a dequeue.
    do_reset();
    found = 1'b0;
    for (int k = 0; k < 30; k++) begin
      if (mem_q.size() > 0 && mem_q[0].due <= cyc && mq.size() > 0) begin
        found = 1'b1;
        break;
      end
      step(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 2);
    end
    chk("sim_setup", found, 1'b1);
    step(1'b0, 1'b1, 32'h0000_5001, 1'b1, 1'b1, 2);
    step(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 2);
    chk("sim_valid_after", obs_valid, 1'b0);
    chk("sim_addr_after", obs_addr, 32'h5000);
    n = 0;
    for (int k = 0; k < 30 && n < 1; k++) begin
      step(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 2);
      if (obs_pop) begin
        chk("sim_first_pc", obs_pc, 32'h5000);
        n++;
      end
    end
    chk("sim_delivered", 32'(n), 32'd1);

    // Random back-pressure, latency and occasional redirects.
    do_reset();
    xmask = $urandom;
    n = 0;
    for (int k = 0; k < 3000; k++) begin
      bit rd;
      rd = (k > 40) && ($urandom_range(0, 39) == 0);
      step(1'b0, rd, $urandom, 1'($urandom_range(0, 1)),
           $urandom_range(0, 3) != 0, int'($urandom_range(1, 4)));
      if (obs_pop && n == 0) begin
        chk("rand_first_pc", obs_pc, 32'h3000);
        n++;
      end
    end
    chk("rand_delivered", 32'(n), 32'd1);

    // Reset with three entries queued and one fetch outstanding.
    do_reset();
    xmask = 32'h0;
    found = 1'b0;
    for (int k = 0; k < 30; k++) begin
      if (mq.size() == 3 && mem_q.size() == 1) begin
        found = 1'b1;
        break;
      end
      step(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 2);
    end
    chk("midrst_setup", found, 1'b1);
    step(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1);
    step(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 1);
    chk("midrst_valid", obs_valid, 1'b0);
    chk("midrst_req", obs_req, 1'b1);
    chk("midrst_addr", obs_addr, 32'h3000);
    n = 0;
    for (int k = 0; k < 20 && n < 1; k++) begin
      step(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 1);
      if (obs_pop) begin
        chk("midrst_first_pc", obs_pc, 32'h3000);
        n++;
      end
    end
    chk("midrst_delivered", 32'(n), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog cyc=%0d got=timeout expected=finish", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule
